// File: rtl/mioc_chk_pkg.sv
// Shared types and constants for the MIOC gate-test response checker.
package mioc_chk_pkg;

    typedef logic [1:0] chk_state_t;

    localparam chk_state_t ST_IDLE   = 2'd0;
    localparam chk_state_t ST_SETTLE = 2'd1;
    localparam chk_state_t ST_SAMPLE = 2'd2;
    localparam chk_state_t ST_REPORT = 2'd3;

    localparam int PAT_W_DEF = 4;

    // res_data = {pat_data, exp_z, got_z}
    localparam int RES_GOT_BIT = 0;
    localparam int RES_EXP_BIT = 1;
    localparam int RES_PAT_LSB = 2;

    function automatic int res_w(input int pat_w);
        return pat_w + 2;
    endfunction

    localparam int RES_W = res_w(PAT_W_DEF);

endpackage

// File: rtl/mioc_sync2.sv
// Two-flop synchronizer for a single asynchronous level; resets to 0.
module mioc_sync2 (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic s1_q;
    logic s2_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
        end else begin
            s1_q <= d;
            s2_q <= s1_q;
        end
    end

    assign q = s2_q;

endmodule

// File: rtl/mioc_resp_checker.sv
// Receive side of the MIOC gate-test flow: settle, sample, report, tally.
// Optional stop-on-first-fail latch enabled by defining MIOC_CHK_STOP_ON_FAIL_EN.
//
// state      | meaning
// -----------+-------------------------------------------------------
// ST_IDLE    | waiting for the applier to present a pattern
// ST_SETTLE  | gate settling; down-counter runs SETTLE_CYC cycles
// ST_SAMPLE  | capture synchronized gate output, update tallies
// ST_REPORT  | result record held until the consumer takes it
module mioc_resp_checker
    import mioc_chk_pkg::*;
#(
    parameter int PAT_W      = 4,
    parameter int SETTLE_CYC = 10,
    parameter int CNT_W      = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               pat_valid,
    output logic               pat_ready,
    input  logic [PAT_W-1:0]   pat_data,
    input  logic               exp_z,
    input  logic               dut_z,
    output logic               res_valid,
    input  logic               res_ready,
    output logic [PAT_W+1:0]   res_data,
    output logic               res_fail,
    output logic [CNT_W-1:0]   pass_cnt,
    output logic [CNT_W-1:0]   fail_cnt,
    input  logic               clear,
    output logic               halted
);

    localparam int TMR_W = $clog2(SETTLE_CYC + 1);
    localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(SETTLE_CYC - 1);

    chk_state_t       state_q, state_d;
    logic [TMR_W-1:0] tmr_q, tmr_d;
    logic [PAT_W-1:0] pat_q, pat_d;
    logic             exp_q, exp_d;
    logic             got_q, got_d;
    logic [CNT_W-1:0] pass_q, pass_d;
    logic [CNT_W-1:0] fail_q, fail_d;
    logic             run_q;
    logic             halt_q;
    logic             z_s;
    logic             accept;
    logic             mismatch;

    mioc_sync2 u_sync_z (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (dut_z),
        .q     (z_s)
    );

`ifdef MIOC_CHK_STOP_ON_FAIL_EN
    logic halt_d;
    assign halted = halt_q;
`else
    assign halt_q = 1'b0;
    assign halted = 1'b0;
`endif

    // run_q keeps pat_ready low while reset is asserted and for the first edge after
    assign pat_ready = (state_q == ST_IDLE) && !halt_q && run_q;
    assign accept    = pat_valid && pat_ready && !clear;
    assign mismatch  = z_s ^ exp_q;

    always_comb begin
        state_d = state_q;
        tmr_d   = tmr_q;
        pat_d   = pat_q;
        exp_d   = exp_q;
        got_d   = got_q;
        pass_d  = pass_q;
        fail_d  = fail_q;
`ifdef MIOC_CHK_STOP_ON_FAIL_EN
        halt_d  = halt_q;
`endif
        if (clear) begin
            state_d = ST_IDLE;
            pass_d  = '0;
            fail_d  = '0;
`ifdef MIOC_CHK_STOP_ON_FAIL_EN
            halt_d  = 1'b0;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        pat_d   = pat_data;
                        exp_d   = exp_z;
                        tmr_d   = TMR_LOAD;
                        state_d = ST_SETTLE;
                    end
                end
                ST_SETTLE: begin
                    if (tmr_q == '0) begin
                        state_d = ST_SAMPLE;
                    end else begin
                        tmr_d = tmr_q - 1'b1;
                    end
                end
                ST_SAMPLE: begin
                    got_d   = z_s;
                    state_d = ST_REPORT;
                    if (mismatch) begin
                        if (!halt_q && (fail_q != '1)) begin
                            fail_d = fail_q + 1'b1;
                        end
`ifdef MIOC_CHK_STOP_ON_FAIL_EN
                        halt_d = 1'b1;
`endif
                    end else if (pass_q != '1) begin
                        pass_d = pass_q + 1'b1;
                    end
                end
                ST_REPORT: begin
                    if (res_ready) begin
                        state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            tmr_q   <= '0;
            pat_q   <= '0;
            exp_q   <= 1'b0;
            got_q   <= 1'b0;
            pass_q  <= '0;
            fail_q  <= '0;
            run_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            tmr_q   <= tmr_d;
            pat_q   <= pat_d;
            exp_q   <= exp_d;
            got_q   <= got_d;
            pass_q  <= pass_d;
            fail_q  <= fail_d;
            run_q   <= 1'b1;
        end
    end

`ifdef MIOC_CHK_STOP_ON_FAIL_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            halt_q <= 1'b0;
        end else begin
            halt_q <= halt_d;
        end
    end
`endif

    assign res_valid = (state_q == ST_REPORT);
    assign res_data  = {pat_q, exp_q, got_q};
    assign res_fail  = res_valid && (got_q != exp_q);
    assign pass_cnt  = pass_q;
    assign fail_cnt  = fail_q;

endmodule
